// File: rtl/i2s_mic_capture.sv
// i2s_mic_capture: deserialises NUM_LINES I2S lines (two mics each) and
// streams each captured half-frame one sample per valid/ready handshake.
// Ports: clk, rst_n (async, active low); bit_clk, lr_clk, sd_in (async I2S);
//   out_valid/out_ready/out_sample/out_mic/out_last (sample stream);
//   overrun (sticky drop flag), clr_overrun (clears overrun and frame_err);
//   frame_err (sticky slot-length error).
// Optional macro I2S_CAP_WS_CHECK_EN enables the slot-length check;
//   when it is undefined frame_err is tied to 0.
module i2s_mic_capture #(
    parameter int NUM_LINES = 8,
    parameter int SAMPLE_W  = 18,
    parameter int SLOT_W    = 32,
    parameter int MIC_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bit_clk,
    input  logic                 lr_clk,
    input  logic [NUM_LINES-1:0] sd_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SAMPLE_W-1:0]  out_sample,
    output logic [MIC_W-1:0]     out_mic,
    output logic                 out_last,
    output logic                 overrun,
    input  logic                 clr_overrun,
    output logic                 frame_err
);
    localparam int LINE_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int CNT_W  = $clog2(SAMPLE_W + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(SAMPLE_W);
    localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(NUM_LINES - 1);

    if (SLOT_W < SAMPLE_W) begin : g_bad_slot
        $error("SLOT_W must be at least SAMPLE_W");
    end

    typedef enum logic {IDLE, STREAM} state_t;

    logic [1:0]           bck_sync;
    logic [1:0]           ws_sync;
    logic [NUM_LINES-1:0] sd_meta;
    logic [NUM_LINES-1:0] sd_sync;
    logic                 bck_prev;
    logic                 ws_prev;
    logic                 armed;
    logic [CNT_W-1:0]     bit_cnt;
    logic [SAMPLE_W-1:0]  shreg  [NUM_LINES];
    logic [SAMPLE_W-1:0]  shnext [NUM_LINES];
    logic [SAMPLE_W-1:0]  bank   [NUM_LINES];
    logic                 side;
    logic [LINE_W-1:0]    line;
    state_t               state;
    state_t               state_nxt;
    logic                 bit_ev;
    logic                 ws_edge;
    logic                 shift_en;
    logic                 capture;
    logic                 hs;
    logic                 final_hs;
    logic                 load;
    logic                 ovr_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bck_sync <= '0;
            ws_sync  <= '0;
            sd_meta  <= '0;
            sd_sync  <= '0;
            bck_prev <= 1'b0;
        end else begin
            bck_sync <= {bck_sync[0], bit_clk};
            ws_sync  <= {ws_sync[0], lr_clk};
            sd_meta  <= sd_in;
            sd_sync  <= sd_meta;
            bck_prev <= bck_sync[1];
        end
    end

    assign bit_ev   = bck_sync[1] & ~bck_prev;
    assign ws_edge  = bit_ev & (ws_sync[1] != ws_prev);
    assign shift_en = bit_ev & (bit_cnt < CNT_MAX);
    assign capture  = ws_edge & armed;

    // The edge event still carries the old slot's LSB, so the captured
    // word includes that bit whenever the slot is not yet saturated.
    always_comb begin
        for (int i = 0; i < NUM_LINES; i++) begin
            shnext[i] = shift_en ? {shreg[i][SAMPLE_W-2:0], sd_sync[i]}
                                 : shreg[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ws_prev <= 1'b0;
            armed   <= 1'b0;
            bit_cnt <= '0;
            shreg   <= '{default: '0};
        end else if (bit_ev) begin
            ws_prev <= ws_sync[1];
            shreg   <= shnext;
            if (ws_edge) begin
                armed   <= 1'b1;
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    assign out_valid = (state == STREAM);
    assign hs        = out_valid & out_ready;
    assign final_hs  = hs & (line == LINE_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        ovr_set   = 1'b0;
        unique case (state)
            IDLE: begin
                if (capture) begin
                    load      = 1'b1;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (final_hs) begin
                    // A capture landing on the last handshake is taken.
                    if (capture) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (capture) begin
                    ovr_set = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank    <= '{default: '0};
            side    <= 1'b0;
            line    <= '0;
            overrun <= 1'b0;
        end else begin
            if (load) begin
                bank <= shnext;
                side <= ws_prev;
                line <= '0;
            end else if (final_hs) begin
                line <= '0;
            end else if (hs) begin
                line <= line + 1'b1;
            end
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

    assign out_sample = bank[line];
    assign out_mic    = MIC_W'({line, side});
    assign out_last   = out_valid & (line == LINE_MAX);

`ifdef I2S_CAP_WS_CHECK_EN
    localparam int SLOT_CW = $clog2(SLOT_W + 1) + 1;

    logic [SLOT_CW-1:0] slot_cnt;
    logic [SLOT_CW-1:0] slot_now;

    // Count including the current event; saturate so long slots stay bad.
    assign slot_now = (slot_cnt == '1) ? slot_cnt : slot_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt  <= '0;
            frame_err <= 1'b0;
        end else begin
            if (bit_ev) begin
                slot_cnt <= ws_edge ? '0 : slot_now;
            end
            if (capture && (slot_now != SLOT_CW'(SLOT_W))) begin
                frame_err <= 1'b1;
            end else if (clr_overrun) begin
                frame_err <= 1'b0;
            end
        end
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule
